hilo_muldiv_seq: RTL
====================

# hilo_muldiv_seq

Multi-cycle signed multiply/divide sequencer that computes a 64-bit result and loads it into the CPU's HI/LO register pair. It sits between the control unit and the 64-bit HI/LO register. It accepts one operation per start pulse, iterates one bit per clock, and then drives the register's D input and load enable for exactly one cycle. Control sees a busy/done handshake.

## Interface
- No parameters; the datapath is fixed at 32-bit operands and a 64-bit result.
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  launch request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide; latched with start
- a  in  32  multiplicand or dividend, two's complement; latched with start
- b  in  32  multiplier or divisor, two's complement; latched with start
- busy  out  1  high from the cycle after accept through the WRITE cycle
- done  out  1  one-cycle completion pulse
- dz_err  out  1  divide-by-zero flag; pulses with done
- hilo_d  out  64  HI in [63:32], LO in [31:0]
- hilo_en  out  1  load enable to the HI/LO register; one cycle per completed operation

## Operation
- States:
  - IDLE: start=1 latches op, a, b, then goes to RUN with count=31.
  - RUN: one iteration per cycle; count decrements; count==0 goes to WRITE.
  - WRITE: hilo_en=1, done=1, then back to IDLE.
- Multiply: radix-2 Booth on the signed operands. Result is the full 64-bit signed product; HI = product[63:32], LO = product[31:0].
- Divide: restoring division on the magnitudes |a| and |b| (33-bit internal remainder), followed by a sign fixup.
  - LO = quotient, truncated toward zero, negated when sign(a)^sign(b).
  - HI = remainder, with the sign of a.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (wraps, no flag).
- Operands are latched at accept. Changes on a, b, op while busy have no effect.
- start while busy is ignored: no queuing, no error.
- hilo_d holds its last written value and changes only on entry to WRITE.

## Timing
- Reset: synchronous, when clr=1 at a rising edge.
  - State=IDLE; busy, done, dz_err, hilo_en = 0; hilo_d = 0; count = 0.
  - clr overrides start in the same cycle.
  - clr during RUN aborts the operation: no hilo_en and no done are ever produced for it.
- Accept edge is cycle 0. RUN occupies cycles 1–32. WRITE is cycle 33 (hilo_en=done=1). busy is high in cycles 1–33. Next accept is possible in cycle 34.
- Fixed latency of 33 cycles for both operations; there is no early termination.
- The register captures hilo_d on the edge ending cycle 33.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: HILO_DIV_ZERO_TRAP_EN.
- Defined: a divide with b==0 at accept goes from IDLE straight to a DZ state in cycle 1.
  - In that cycle: done=1, dz_err=1, busy=1, hilo_en=0, so HI/LO are not modified.
  - Returns to IDLE in cycle 2.
- Undefined: dz_err is tied to 0, and divide by zero runs the full 32 iterations.
  - Result: LO=0xFFFFFFFF if a≥0, else 0x00000001; HI=a. This is the natural output of the restoring algorithm with the fixup.
  - Latency is 33 cycles, as for any divide.

## Test plan
- Multiply a=7, b=-3 → cycle 33: hilo_en=1, hilo_d=0xFFFFFFFF_FFFFFFEB. busy high in cycles 1–33 only.
- Multiply a=b=0x80000000 → hilo_d=0x40000000_00000000. Also check a=0x7FFFFFFF, b=-1 → 0xFFFFFFFF_80000001.
- Divide a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also divide a=0x80000000, b=-1 → LO=0x80000000, HI=0.
- Divide a=5, b=0:
  - With the macro: cycle 1 done=dz_err=1, hilo_en never asserted.
  - Without the macro: cycle 33 hilo_d=0x00000005_FFFFFFFF, dz_err=0.
- Pulse start with new operands in cycles 5 and 20 of a multiply → ignored. The result matches the original operands, and exactly one hilo_en occurs.
- Assert clr in cycle 10 of a divide → next cycle busy=0 and hilo_d=0; no done or hilo_en follows. A fresh start then completes normally.

Source files
------------

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) sequencer feeding HI/LO.
// Optional macro HILO_DIV_ZERO_TRAP_EN: divide by zero ends early in a DZ state with dz_err_o.
module hilo_muldiv_seq (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dz_err_o,
    output logic [63:0] hilo_d_o,
    output logic        hilo_en_o
);

    typedef enum logic [1:0] {StIdle, StRun, StWrite, StDz} state_e;

    state_e      state_q;
    logic [4:0]  count_q;
    logic        op_q;
    logic        quot_neg_q;
    logic        rem_neg_q;
    logic        qm1_q;
    logic [32:0] acc_q;
    logic [31:0] q_q;
    logic [31:0] mcand_q;
    logic        busy_q;
    logic        done_q;
    logic        hilo_en_q;
    logic [63:0] hilo_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] booth_sum;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [32:0] acc_nx;
    logic [31:0] q_nx;
    logic        qm1_nx;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [63:0] result;

    assign a_mag = a_i[31] ? (32'h0 - a_i) : a_i;
    assign b_mag = b_i[31] ? (32'h0 - b_i) : b_i;

    // One iteration of whichever algorithm is in flight; acc is 33 bits so the Booth
    // partial product cannot overflow even for a multiplicand of -2^31.
    always_comb begin
        booth_sum = acc_q;
        rem_sh    = {acc_q[31:0], q_q[31]};
        diff      = {1'b0, rem_sh} - {2'b00, mcand_q};
        acc_nx    = acc_q;
        q_nx      = q_q;
        qm1_nx    = qm1_q;
        if (!op_q) begin
            case ({q_q[0], qm1_q})
                2'b01:   booth_sum = acc_q + {mcand_q[31], mcand_q};
                2'b10:   booth_sum = acc_q - {mcand_q[31], mcand_q};
                default: booth_sum = acc_q;
            endcase
            acc_nx = {booth_sum[32], booth_sum[32:1]};
            q_nx   = {booth_sum[0], q_q[31:1]};
            qm1_nx = q_q[0];
        end else if (diff[33]) begin
            acc_nx = rem_sh;
            q_nx   = {q_q[30:0], 1'b0};
        end else begin
            acc_nx = diff[32:0];
            q_nx   = {q_q[30:0], 1'b1};
        end
    end

    always_comb begin
        quot_fix = quot_neg_q ? (32'h0 - q_nx) : q_nx;
        rem_fix  = rem_neg_q ? (32'h0 - acc_nx[31:0]) : acc_nx[31:0];
        result   = op_q ? {rem_fix, quot_fix} : {acc_nx[31:0], q_nx};
    end

`ifdef HILO_DIV_ZERO_TRAP_EN
    logic dz_err_q;
`endif

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= StIdle;
            count_q    <= '0;
            op_q       <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            qm1_q      <= 1'b0;
            acc_q      <= '0;
            q_q        <= '0;
            mcand_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hilo_en_q  <= 1'b0;
            hilo_q     <= '0;
`ifdef HILO_DIV_ZERO_TRAP_EN
            dz_err_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            hilo_en_q <= 1'b0;
`ifdef HILO_DIV_ZERO_TRAP_EN
            dz_err_q  <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        count_q <= 5'd31;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        state_q <= StRun;
                        if (op_i) begin
                            q_q        <= a_mag;
                            mcand_q    <= b_mag;
                            quot_neg_q <= a_i[31] ^ b_i[31];
                            rem_neg_q  <= a_i[31];
                        end else begin
                            q_q     <= b_i;
                            mcand_q <= a_i;
                        end
`ifdef HILO_DIV_ZERO_TRAP_EN
                        if (op_i && (b_i == 32'h0)) begin
                            state_q  <= StDz;
                            done_q   <= 1'b1;
                            dz_err_q <= 1'b1;
                        end
`endif
                    end
                end
                StRun: begin
                    acc_q <= acc_nx;
                    q_q   <= q_nx;
                    qm1_q <= qm1_nx;
                    if (count_q == 5'd0) begin
                        state_q   <= StWrite;
                        hilo_q    <= result;
                        hilo_en_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        count_q <= count_q - 5'd1;
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign hilo_en_o = hilo_en_q;
    assign hilo_d_o  = hilo_q;
`ifdef HILO_DIV_ZERO_TRAP_EN
    assign dz_err_o  = dz_err_q;
`else
    assign dz_err_o  = 1'b0;
`endif

endmodule
